// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared types and constants for the UART TX arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int UART_DW = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  // Index width for n requesters, never below one bit.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin pick, scanning from last_id+1 with
//           last_id itself considered last.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N_REQ = 4,
  parameter int GW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    last_id,
  output logic [GW-1:0]    winner,
  output logic             valid
);

  logic [GW-1:0] w_idx;

  // Walk downwards so the closest requester after last_id overwrites the rest.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    w_idx  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_idx = GW'((int'(last_id) + k) % N_REQ);
      if (req[w_idx]) begin
        winner = w_idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module  : uart_tx_arbiter
// Brief   : Round-robin arbiter sharing one UART transmitter between N_REQ
//           byte producers, with optional burst lock and start timeout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int N_REQ         = 4,
  parameter  int MAX_BURST     = 16,
  parameter  int START_TIMEOUT = 64,
  localparam int GW            = idx_width(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         req_lock,
  input  logic [UART_DW*N_REQ-1:0] din,
  output logic [N_REQ-1:0]         ack,
  output logic                     tx_start,
  output logic [UART_DW-1:0]       tx_data,
  input  logic                     tx_busy,
  output logic [GW-1:0]            grant_id,
  output logic                     busy,
  output logic                     err
);

  localparam int                   c_TO_W      = $clog2(START_TIMEOUT + 1);
  localparam int                   c_BURST_W   = $clog2(MAX_BURST + 1);
  localparam logic [c_TO_W-1:0]    c_TO_LAST   = c_TO_W'(START_TIMEOUT - 1);
  localparam logic [c_BURST_W-1:0] c_MAX_BURST = c_BURST_W'(MAX_BURST);
  localparam logic [c_BURST_W-1:0] c_BURST_ONE = c_BURST_W'(1);

  arb_state_t             r_state;
  arb_state_t             w_state_nxt;
  logic [GW-1:0]          r_grant_id;
  logic [GW-1:0]          r_rr_last;
  logic [UART_DW-1:0]     r_tx_data;
  logic                   r_lock;
  logic                   r_err;
  logic [c_BURST_W-1:0]   r_burst_cnt;
  logic [c_TO_W-1:0]      r_to_cnt;

  logic [UART_DW-1:0]     w_din_arr [N_REQ];
  logic [GW-1:0]          w_rr_winner;
  logic                   w_rr_valid;
  logic                   w_lock_hit;
  logic [GW-1:0]          w_pick;
  logic                   w_pick_valid;
  logic                   w_timeout;

  for (genvar i = 0; i < N_REQ; i++) begin : g_din_split
    assign w_din_arr[i] = din[UART_DW*i +: UART_DW];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .GW    (GW)
  ) u_rr_pick (
    .req     (req),
    .last_id (r_rr_last),
    .winner  (w_rr_winner),
    .valid   (w_rr_valid)
  );

  // A held lock only survives while its owner still requests and has budget left.
  assign w_lock_hit   = r_lock && req[r_grant_id] && (r_burst_cnt < c_MAX_BURST);
  assign w_pick       = w_lock_hit ? r_grant_id : w_rr_winner;
  assign w_pick_valid = w_lock_hit | w_rr_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    tx_start    = 1'b0;
    ack         = '0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) w_state_nxt = LAUNCH;
      end
      LAUNCH: begin
        tx_start        = 1'b1;
        ack[r_grant_id] = 1'b1;
        w_state_nxt     = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          w_state_nxt = WAIT_DONE;
        end else if (r_to_cnt == c_TO_LAST) begin
          w_state_nxt = IDLE;
          w_timeout   = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant_id  <= '0;
      r_rr_last   <= GW'(N_REQ - 1);
      r_tx_data   <= '0;
      r_lock      <= 1'b0;
      r_err       <= 1'b0;
      r_burst_cnt <= '0;
      r_to_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_timeout;
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_tx_data  <= w_din_arr[w_pick];
            r_grant_id <= w_pick;
            r_rr_last  <= w_pick;
            // Count only back-to-back bytes of the same grantee; saturate at the limit.
            if ((r_burst_cnt != '0) && (w_pick == r_grant_id)) begin
              if (r_burst_cnt != c_MAX_BURST) r_burst_cnt <= r_burst_cnt + 1'b1;
            end else begin
              r_burst_cnt <= c_BURST_ONE;
            end
          end
        end
        LAUNCH: begin
          r_lock   <= req_lock[r_grant_id];
          r_to_cnt <= '0;
        end
        WAIT_BUSY: begin
          if (w_timeout) r_lock <= 1'b0;
          else if (!tx_busy) r_to_cnt <= r_to_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign tx_data  = r_tx_data;
  assign grant_id = r_grant_id;
  assign busy     = (r_state != IDLE);
  assign err      = r_err;

endmodule

`default_nettype wire
